// File: rtl/control_multiplicador.sv
// control_multiplicador: control FSM and operand/result handshake
// wrapper for the shift-add multiplier datapath.
module control_multiplicador #(
    parameter int ANCHO = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ANCHO-1:0]   multiplicando_in,
    input  logic [ANCHO-1:0]   multiplicador_in,
    output logic [ANCHO-1:0]   Multiplicando,
    output logic [ANCHO-1:0]   Multiplicador,
    output logic               Load_regs,
    output logic               Add_regs,
    output logic               Shift_regs,
    output logic               Decr_P,
    input  logic               Q_Cero,
    input  logic               Zero,
    input  logic [2*ANCHO:0]   Producto,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*ANCHO-1:0] resultado,
    output logic               err
);
    localparam int CW = $clog2(ANCHO + 1);
    localparam logic [CW-1:0] ITERS = CW'(ANCHO);

    typedef enum logic [2:0] {
        IDLE, LOAD, CHECK, ADD, SHIFT, DECR, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ANCHO-1:0]   mcand_q, mcand_d;
    logic [ANCHO-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      iter_q, iter_d;
    logic [2*ANCHO-1:0] res_q, res_d;
    logic               err_q, err_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               load_q, load_d;
    logic               add_q, add_d;
    logic               shift_q, shift_d;
    logic               decr_q, decr_d;

    // Next state, operand/result capture, watchdog and output decode.
    // Outputs are decoded from the next state so they leave a flop.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        iter_d   = iter_q;
        res_d    = res_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    mcand_d  = multiplicando_in;
                    mplier_d = multiplicador_in;
                    iter_d   = '0;
                    err_d    = 1'b0;
                    state_d  = LOAD;
                end
            end
            LOAD: state_d = CHECK;
            CHECK: begin
                if (Zero) begin
                    res_d   = Producto[2*ANCHO-1:0];
                    err_d   = (iter_q != ITERS);
                    state_d = DONE;
                end else if (iter_q == ITERS) begin
                    res_d   = Producto[2*ANCHO-1:0];
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (Q_Cero) begin
                    state_d = ADD;
                end else begin
                    state_d = SHIFT;
                end
            end
            ADD:   state_d = SHIFT;
            SHIFT: state_d = DECR;
            DECR: begin
                iter_d  = iter_q + CW'(1);
                state_d = CHECK;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        load_d      = (state_d == LOAD);
        add_d       = (state_d == ADD);
        shift_d     = (state_d == SHIFT);
        decr_d      = (state_d == DECR);
    end

    // State and output registers; reset drops every command at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            iter_q      <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            load_q      <= 1'b0;
            add_q       <= 1'b0;
            shift_q     <= 1'b0;
            decr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            iter_q      <= iter_d;
            res_q       <= res_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            load_q      <= load_d;
            add_q       <= add_d;
            shift_q     <= shift_d;
            decr_q      <= decr_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign Multiplicando = mcand_q;
    assign Multiplicador = mplier_q;
    assign Load_regs     = load_q;
    assign Add_regs      = add_q;
    assign Shift_regs    = shift_q;
    assign Decr_P        = decr_q;
    assign resultado     = res_q;
    assign err           = err_q;

endmodule

// File: tb/tb_control_multiplicador.sv
// tb_control_multiplicador: random and directed products against a
// behavioural shift-add datapath and arithmetic reference.
module tb_control_multiplicador;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  multiplicando_in = '0;
    logic [7:0]  multiplicador_in = '0;
    logic [7:0]  Multiplicando;
    logic [7:0]  Multiplicador;
    logic        Load_regs, Add_regs, Shift_regs, Decr_P;
    logic        Q_Cero, Zero;
    logic [16:0] Producto;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] resultado;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic       dp_e;
    logic [7:0] dp_a, dp_q;
    logic [3:0] dp_p;

    int seq[$];
    int viol = 0;
    int dec_total = 0;
    int dec_base = 0;
    int zero_mode = 0;

    control_multiplicador #(.ANCHO(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .multiplicando_in(multiplicando_in),
        .multiplicador_in(multiplicador_in),
        .Multiplicando(Multiplicando),
        .Multiplicador(Multiplicador),
        .Load_regs(Load_regs), .Add_regs(Add_regs),
        .Shift_regs(Shift_regs), .Decr_P(Decr_P),
        .Q_Cero(Q_Cero), .Zero(Zero), .Producto(Producto),
        .out_valid(out_valid), .out_ready(out_ready),
        .resultado(resultado), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: {E,A,Q} register and down counter P.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_e <= 1'b0; dp_a <= '0; dp_q <= '0; dp_p <= '0;
        end else if (Load_regs) begin
            dp_e <= 1'b0; dp_a <= '0;
            dp_q <= Multiplicador; dp_p <= 4'd8;
        end else if (Add_regs) begin
            {dp_e, dp_a} <= {1'b0, dp_a} + {1'b0, Multiplicando};
        end else if (Shift_regs) begin
            {dp_e, dp_a, dp_q} <= {1'b0, dp_e, dp_a, dp_q[7:1]};
        end else if (Decr_P) begin
            dp_p <= dp_p - 4'd1;
        end
    end

    assign Producto = {dp_e, dp_a, dp_q};
    assign Q_Cero   = dp_q[0];
    assign Zero = (zero_mode == 1) ? 1'b0 :
                  (zero_mode == 2 && dec_total - dec_base >= 2) ? 1'b1 :
                  (dp_p == 4'd0);

    // Command monitor: log order, count multi-hot cycles and decrements.
    always @(negedge clk) begin
        if (rst) begin
            if (int'(Load_regs) + int'(Add_regs) + int'(Shift_regs)
                + int'(Decr_P) > 1) viol++;
            if (Load_regs)  seq.push_back(1);
            if (Add_regs)   seq.push_back(2);
            if (Shift_regs) seq.push_back(3);
            if (Decr_P) begin
                seq.push_back(4);
                dec_total++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input int hold, input int zmode);
        int n, base, vbase, iters, lat;
        int exp_q[$];
        logic ok, exp_err;
        logic [15:0] r0;
        zero_mode = zmode;
        iters = (zmode == 2) ? 2 : 8;
        exp_err = (zmode != 0);
        lat = 2;
        exp_q.push_back(1);
        for (int i = 0; i < iters; i++) begin
            lat += 3 + int'(b[i]);
            if (b[i]) exp_q.push_back(2);
            exp_q.push_back(3);
            exp_q.push_back(4);
        end
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_rdy", in_ready, 1);
        base = seq.size();
        vbase = viol;
        dec_base = dec_total;
        multiplicando_in = a;
        multiplicador_in = b;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        n = 0;
        ok = 1'b1;
        while (!out_valid && n < 300) begin
            in_valid = 1'($urandom);
            multiplicando_in = 8'($urandom);
            multiplicador_in = 8'($urandom);
            @(posedge clk); #1;
            n++;
            if (in_ready) ok = 1'b0;
        end
        in_valid = 1'b0;
        chk("busy_rdy", ok, 1);
        chk("out_valid", out_valid, 1);
        chk("latency", n, lat);
        chk("err", err, exp_err);
        if (zmode == 0) chk("product", resultado, 16'(a) * 16'(b));
        chk("hold_b", Multiplicando, a);
        chk("hold_q", Multiplicador, b);
        chk("decr_cnt", dec_total - dec_base, iters);
        chk("onehot", viol - vbase, 0);
        ok = (seq.size() - base == exp_q.size());
        if (ok) begin
            for (int i = 0; i < exp_q.size(); i++)
                if (seq[base + i] != exp_q[i]) ok = 1'b0;
        end
        chk("cmd_seq", ok, 1);
        r0 = resultado;
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            if (!out_valid || resultado !== r0 || in_ready || err !== exp_err)
                ok = 1'b0;
        end
        if (hold > 0) chk("hold_stable", ok, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_clr", {out_valid, in_ready}, 2'b01);
        out_ready = 1'b0;
        zero_mode = 0;
    endtask

    initial begin
        int n, sh;
        #1;
        chk("rst_ctl", {in_ready, out_valid, Load_regs, Add_regs,
                        Shift_regs, Decr_P, err}, 0);
        chk("rst_res", resultado, 0);
        chk("rst_hold", {Multiplicando, Multiplicador}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rdy_pre_edge", in_ready, 0);
        @(posedge clk); #1;
        chk("rdy_post_rst", in_ready, 1);

        do_op(8'd13, 8'd11, 0, 0);
        do_op(8'd255, 8'd255, 10, 0);
        do_op(8'd7, 8'd6, 0, 0);
        do_op(8'hC8, 8'd0, 1, 0);
        for (int i = 0; i < 8; i++)
            do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 0);

        multiplicando_in = 8'd200;
        multiplicador_in = 8'd255;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sh = 0;
        n = 0;
        while (sh < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (Shift_regs) sh++;
        end
        chk("shift3_seen", sh, 4);
        rst = 1'b0;
        #1;
        chk("mid_rst_ctl", {in_ready, out_valid, Load_regs, Add_regs,
                            Shift_regs, Decr_P, err}, 0);
        chk("mid_rst_res", resultado, 0);
        sh = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid || in_ready) sh++;
        end
        chk("mid_rst_quiet", sh, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rdy_pre", in_ready, 0);
        @(posedge clk); #1;
        chk("mid_rdy_post", in_ready, 1);
        do_op(8'd9, 8'd9, 0, 0);

        do_op(8'($urandom), 8'($urandom), 2, 1);
        do_op(8'($urandom), 8'($urandom), 0, 2);
        do_op(8'd3, 8'd5, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
